// File: rtl/efuse_pkg.sv
// Shared definitions for the efuse autoload controller: segment geometry defaults
// and the load-sequence FSM state encoding.
package efuse_pkg;

  localparam int unsigned NR_DEF   = 64;
  localparam int unsigned RSEL_DEF = 256 / NR_DEF;

  typedef enum logic [2:0] {
    StIdle,
    StPwrDly,
    StStart,
    StWait,
    StStore,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/efuse_autoload.sv
// Sequences the efuse read engine through every segment after reset or on software
// request, assembling the shadow image and reporting completion or timeout.
module efuse_autoload
  import efuse_pkg::*;
#(
  parameter int unsigned NR       = NR_DEF,
  parameter int unsigned RSEL     = RSEL_DEF,
  parameter int unsigned AUTO_DLY = 16,
  parameter int unsigned TMO      = 4095,
  localparam int unsigned SW      = (RSEL > 1) ? $clog2(RSEL) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  output logic               rd_start,
  output logic [SW-1:0]      rd_sel,
  input  logic               rd_done,
  input  logic               rd_busy,
  input  logic [NR-1:0]      rd_data,
  output logic [NR*RSEL-1:0] shadow,
  output logic [RSEL-1:0]    seg_vld,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err
);

  localparam int unsigned TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam int unsigned DW = (AUTO_DLY > 1) ? $clog2(AUTO_DLY) : 1;

  state_e        state;
  logic [TW-1:0] tmo_cnt;
  logic [DW-1:0] dly_cnt;
  logic [SW-1:0] seg;
  logic          rd_done_d1;
  logic          done_rise;

  // Only a fresh rising edge counts; a done level left over from the previous
  // segment must not complete the current one.
  assign done_rise = rd_done & ~rd_done_d1;
  assign rd_sel    = seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StPwrDly;
      tmo_cnt    <= '0;
      dly_cnt    <= '0;
      seg        <= '0;
      rd_done_d1 <= 1'b0;
      rd_start   <= 1'b0;
      shadow     <= '0;
      seg_vld    <= '0;
      load_busy  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      rd_done_d1 <= rd_done;
      rd_start   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (load_req) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            seg_vld   <= '0;
            seg       <= '0;
            load_busy <= 1'b1;
            state     <= StStart;
          end
        end
        StPwrDly: begin
          if (dly_cnt == DW'(AUTO_DLY - 1)) begin
            dly_cnt <= '0;
            seg     <= '0;
            state   <= StStart;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        StStart: begin
          if (!rd_busy) begin
            rd_start <= 1'b1;
            tmo_cnt  <= '0;
            state    <= StWait;
          end
        end
        StWait: begin
          if (done_rise) begin
            state <= StStore;
          end else if (tmo_cnt == TW'(TMO)) begin
            load_busy <= 1'b0;
            state     <= StErr;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StStore: begin
          shadow[NR*seg +: NR] <= rd_data;
          seg_vld[seg]         <= 1'b1;
          if (seg == SW'(RSEL - 1)) begin
            load_busy <= 1'b0;
            state     <= StDone;
          end else begin
            seg   <= seg + 1'b1;
            state <= StStart;
          end
        end
        StDone: begin
          load_done <= 1'b1;
          state     <= StIdle;
        end
        StErr: begin
          load_err <= 1'b1;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_autoload.sv
// Self-checking bench for efuse_autoload with a behavioural read-engine model.
module tb_efuse_autoload;
  import efuse_pkg::*;

  localparam int unsigned NR   = 64;
  localparam int unsigned RSEL = 4;
  localparam int          LAT  = 40;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_req = 1'b0;
  logic               rd_start;
  logic [1:0]         rd_sel;
  logic               rd_done;
  logic               rd_busy;
  logic [NR-1:0]      rd_data;
  logic [NR*RSEL-1:0] shadow;
  logic [RSEL-1:0]    seg_vld;
  logic               load_busy;
  logic               load_done;
  logic               load_err;

  always #5 clk = ~clk;

  efuse_autoload #(
    .NR       (NR),
    .RSEL     (RSEL),
    .AUTO_DLY (16),
    .TMO      (4095)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .rd_start  (rd_start),
    .rd_sel    (rd_sel),
    .rd_done   (rd_done),
    .rd_busy   (rd_busy),
    .rd_data   (rd_data),
    .shadow    (shadow),
    .seg_vld   (seg_vld),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // Read-engine model: done/data LAT cycles after start; hang_seg never completes;
  // late_clr delays clearing the done level after start.
  logic [NR-1:0] words [RSEL];
  int            hang_seg = -1;
  int            late_clr = 0;
  logic          force_busy = 1'b0;
  logic          mdl_busy;
  int            mdl_cnt;
  int            clr_cnt;
  logic [1:0]    cur;

  assign rd_busy = mdl_busy | force_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0;
      rd_done  <= 1'b0;
      rd_data  <= '0;
      mdl_cnt  <= 0;
      clr_cnt  <= 0;
      cur      <= '0;
    end else if (rd_start) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= LAT;
      cur      <= rd_sel;
      clr_cnt  <= late_clr;
      if (late_clr == 0) rd_done <= 1'b0;
    end else if (mdl_busy) begin
      if (clr_cnt == 1) rd_done <= 1'b0;
      if (clr_cnt > 0) clr_cnt <= clr_cnt - 1;
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_busy <= 1'b0;
        if (int'(cur) != hang_seg) begin
          rd_done <= 1'b1;
          rd_data <= words[cur];
        end
      end
    end
  end

  // Monitor: cycle count, rd_start pulses and their rd_sel, load_err rise time.
  int   cyc = 0;
  int   n_starts = 0;
  int   last_start_cyc = 0;
  int   err_cyc = 0;
  int   sel_log[$];
  logic err_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rd_start) begin
      n_starts++;
      sel_log.push_back(int'(rd_sel));
      last_start_cyc = cyc;
    end
    if (load_err && !err_prev) err_cyc = cyc;
    err_prev = load_err;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_words(input logic [15:0] seed);
    for (int i = 0; i < RSEL; i++) words[i] = {seed, 16'(i), ~seed, 16'(i)};
  endtask

  task automatic pulse_req();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (load_busy && n < 20000);
    chk({nm, " busy drop"}, 256'(load_busy), 256'(0));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_start_sel(input string nm, input int sel);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(rd_start && int'(rd_sel) == sel) && n < 5000);
    chk({nm, " start seen"}, 256'(rd_start), 256'(1));
  endtask

  // Cycles from release (index 0 = after first edge) to the first rd_start.
  task automatic chk_first_start(input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rd_start && n < 100);
    chk({nm, " first start cycle"}, 256'(n - 1), 256'(16));
    chk({nm, " first sel"}, 256'(rd_sel), 256'(0));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " rd_start"}, 256'(rd_start), 256'(0));
    chk({nm, " rd_sel"}, 256'(rd_sel), 256'(0));
    chk({nm, " shadow"}, 256'(shadow), 256'(0));
    chk({nm, " seg_vld"}, 256'(seg_vld), 256'(0));
    chk({nm, " load_done"}, 256'(load_done), 256'(0));
    chk({nm, " load_err"}, 256'(load_err), 256'(0));
    chk({nm, " load_busy"}, 256'(load_busy), 256'(1));
  endtask

  task automatic chk_result(input string nm, input logic [3:0] vld, input logic done,
                            input logic err, input int starts, input int sb, input int qb,
                            input logic [255:0] exp_sh);
    chk({nm, " seg_vld"}, 256'(seg_vld), 256'(vld));
    chk({nm, " load_done"}, 256'(load_done), 256'(done));
    chk({nm, " load_err"}, 256'(load_err), 256'(err));
    chk({nm, " load_busy"}, 256'(load_busy), 256'(0));
    chk({nm, " starts"}, 256'(n_starts - sb), 256'(starts));
    for (int i = 0; i < starts; i++)
      chk({nm, " sel order"}, 256'((qb + i < sel_log.size()) ? sel_log[qb + i] : -1), 256'(i));
    chk({nm, " shadow"}, 256'(shadow), exp_sh);
  endtask

  typedef struct {
    int          hang;
    logic [15:0] seed;
    logic [3:0]  vld;
    logic        done;
    logic        err;
    int          starts;
  } vec_t;

  initial begin
    vec_t         tv[5];
    logic [255:0] exp_sh;
    int           sb;
    int           qb;
    int           d;

    tv[0] = '{hang: 2,  seed: 16'hBEEF, vld: 4'h3, done: 1'b0, err: 1'b1, starts: 3};
    tv[1] = '{hang: -1, seed: 16'hC0DE, vld: 4'hF, done: 1'b1, err: 1'b0, starts: 4};
    tv[2] = '{hang: 0,  seed: 16'h1111, vld: 4'h0, done: 1'b0, err: 1'b1, starts: 1};
    tv[3] = '{hang: 3,  seed: 16'h7E57, vld: 4'h7, done: 1'b0, err: 1'b1, starts: 4};
    tv[4] = '{hang: -1, seed: 16'h0A0A, vld: 4'hF, done: 1'b1, err: 1'b0, starts: 4};

    // Power-up autoload.
    set_words(16'h1234);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    exp_sh = '0;
    sb = n_starts;
    qb = sel_log.size();
    @(negedge clk) rst_n = 1'b1;
    chk_first_start("powerup");
    wait_idle("powerup");
    for (int i = 0; i < RSEL; i++) exp_sh[i*NR +: NR] = words[i];
    chk_result("powerup", 4'hF, 1'b1, 1'b0, 4, sb, qb, exp_sh);

    // Table: software reloads with optional hung segment.
    for (int t = 0; t < 5; t++) begin
      set_words(tv[t].seed);
      hang_seg = tv[t].hang;
      sb = n_starts;
      qb = sel_log.size();
      pulse_req();
      chk($sformatf("vec%0d cleared", t), 256'({seg_vld, load_done, load_err, load_busy}),
          256'({4'h0, 1'b0, 1'b0, 1'b1}));
      wait_idle($sformatf("vec%0d", t));
      for (int i = 0; i < RSEL; i++) if (tv[t].vld[i]) exp_sh[i*NR +: NR] = words[i];
      chk_result($sformatf("vec%0d", t), tv[t].vld, tv[t].done, tv[t].err, tv[t].starts,
                 sb, qb, exp_sh);
      if (tv[t].err) begin
        d = err_cyc - last_start_cyc;
        chk($sformatf("vec%0d timeout window", t), 256'(d >= 4095 && d <= 4099), 256'(1));
      end
    end
    hang_seg = -1;

    // load_req during WAIT of segment 1 is ignored.
    set_words(16'h5A5A);
    sb = n_starts;
    qb = sel_log.size();
    pulse_req();
    wait_start_sel("busy req", 1);
    repeat (5) @(posedge clk);
    #1;
    pulse_req();
    chk("busy req keeps vld", 256'(seg_vld), 256'(4'h1));
    chk("busy req keeps busy", 256'(load_busy), 256'(1));
    wait_idle("busy req");
    for (int i = 0; i < RSEL; i++) exp_sh[i*NR +: NR] = words[i];
    chk_result("busy req", 4'hF, 1'b1, 1'b0, 4, sb, qb, exp_sh);

    // Reset during segment 2 WAIT.
    set_words(16'h0F0F);
    pulse_req();
    wait_start_sel("midreset", 2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    sb = n_starts;
    qb = sel_log.size();
    @(negedge clk) rst_n = 1'b1;
    chk_first_start("midreset");
    wait_idle("midreset");
    exp_sh = '0;
    for (int i = 0; i < RSEL; i++) exp_sh[i*NR +: NR] = words[i];
    chk_result("midreset", 4'hF, 1'b1, 1'b0, 4, sb, qb, exp_sh);

    // Stale rd_done with engine busy at START.
    force_busy = 1'b1;
    late_clr = 10;
    sb = n_starts;
    qb = sel_log.size();
    pulse_req();
    repeat (20) @(posedge clk);
    #1;
    chk("stale no start while busy", 256'(n_starts - sb), 256'(0));
    chk("stale done level held", 256'(rd_done), 256'(1));
    @(negedge clk) force_busy = 1'b0;
    wait_start_sel("stale", 0);
    repeat (5) @(posedge clk);
    #1;
    chk("stale level no advance", 256'(seg_vld), 256'(4'h0));
    chk("stale level still high", 256'(rd_done), 256'(1));
    late_clr = 0;
    wait_idle("stale");
    chk_result("stale", 4'hF, 1'b1, 1'b0, 4, sb, qb, exp_sh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
